axi_burst_write_adapter: RTL
============================

AXI_BURST_WRITE_ADAPTER -- requirements
Module: axi_burst_write_adapter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning AXI data width in bits (32 or 64).
REQ-002 SHALL have parameter ID_W, default 4, meaning width of awid/wid/bid.
REQ-003 SHALL have parameter AXI_ID, default 0, meaning constant ID driven on awid/wid and expected on bid.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, write request offered.
REQ-007 SHALL have port req_ready, output, 1, adapter accepts request.
REQ-008 SHALL have port req_addr, input, 32, burst start byte address.
REQ-009 SHALL have port req_len, input, 4, beats minus one (1..16 beats).
REQ-010 SHALL have port req_size, input, 3, bytes per beat as log2.
REQ-011 SHALL have port src_valid, input, 1, write beat offered by source.
REQ-012 SHALL have port src_ready, output, 1, beat consumed this cycle.
REQ-013 SHALL have port src_data, input, DATA_W, beat data.
REQ-014 SHALL have port src_strb, input, DATA_W/8, beat byte enables.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at transaction end.
REQ-016 SHALL have port done_err, output, 1, qualifies done; 1 = SLVERR/DECERR/illegal size.
REQ-017 SHALL have AXI3 write master ports: aw{id,addr,len,size,burst,lock,cache,prot,valid,ready}, w{id,data,strb,last,valid,ready}, b{id,resp,valid,ready}, with standard AXI3 directions and widths (data DATA_W, strb DATA_W/8, id ID_W).

Function
REQ-018 SHALL use states IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL, on req_valid & req_ready, latch addr/len/size, clear beat counter, enter BUSY and assert awvalid the next cycle.
REQ-020 SHALL hold awvalid and all aw* values stable until awready sampled high, then drop awvalid the following cycle.
REQ-021 SHALL drive awlen = latched req_len, awsize = latched req_size, awburst = INCR (2'b01), awlock/awcache/awprot = 0, awid = wid = AXI_ID.
REQ-022 SHALL, in BUSY with beats remaining, drive wvalid = src_valid, wdata = src_data, wstrb = src_strb, src_ready = wready (combinational); outside that condition wvalid = src_ready = 0.
REQ-023 SHALL increment beat counter on each wvalid & wready and assert wlast when counter equals latched len.
REQ-024 SHALL allow W beats to complete before, with, or after the AW handshake.
REQ-025 SHALL enter RESP when both the AW handshake and the last W beat have completed (same-cycle completion allowed).
REQ-026 SHALL assert bready only in RESP; bvalid outside RESP SHALL be ignored.
REQ-027 SHALL, on bvalid & bready with bid = AXI_ID, pulse done the next cycle with done_err = bresp[1], and return to IDLE; a mismatching bid SHALL be consumed and ignored.
REQ-028 SHALL treat req_size > log2(DATA_W/8) as illegal: no AXI activity, done = done_err = 1 the cycle after acceptance, stay IDLE.
REQ-029 SHALL achieve minimum latency of 3 cycles from request acceptance to done for a 1-beat burst with awready = wready = bvalid responsive.
REQ-030 SHALL support one outstanding transaction only.

Reset
REQ-031 SHALL, on reset, clear state to IDLE and drive awvalid, wvalid, wlast, bready, src_ready, done, done_err to 0 the next cycle.
REQ-032 SHALL abandon any burst in progress on reset without issuing done.

Structure
REQ-033 SHALL take AXI burst/response encodings, Valid/InValid, and state encodings from the shared defines file.
REQ-034 SHALL be a single module; no sub-module is required.

Verification
REQ-035 1-beat write addr 0x100, data 0xDEADBEEF, strb 0xF, all readies high -> awlen 0, wlast on beat, done at cycle 3, done_err 0.
REQ-036 4-beat burst, awready delayed 5 cycles, wready high -> all 4 beats sent before AW, wlast on beat 4 only, single done.
REQ-037 8-beat burst with src_valid toggling every other cycle -> exactly 8 W handshakes, data order preserved, counter ends at 7.
REQ-038 bresp = 2'b10 on 2-beat burst -> done = 1 with done_err = 1, state IDLE next cycle.
REQ-039 req_size 3 with DATA_W 32 -> no awvalid/wvalid ever, done & done_err pulse 1 cycle after accept.
REQ-040 reset asserted mid-burst after beat 2 of 4 -> awvalid/wvalid 0 next cycle, no done, new request accepted afterwards.

Source files
------------

// File: rtl/axi_burst_write_adapter_pkg.sv
// Shared encodings for the AXI3 burst write adapter.
// This covers the adapter states, the valid levels and the AXI burst/response codes.
package axi_burst_write_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_burst_write_adapter.sv
// Converts a single request plus a beat stream into one AXI3 INCR write burst.
// Only one transaction is outstanding at a time.
module axi_burst_write_adapter
  import axi_burst_write_adapter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic [3:0]          req_len,
  input  logic [2:0]          req_size,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [DATA_W-1:0]   src_data,
  input  logic [DATA_W/8-1:0] src_strb,
  output logic                done,
  output logic                done_err,
  output logic [ID_W-1:0]     awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int              STRB_W   = DATA_W / 8;
  localparam logic [2:0]      MAX_SIZE = 3'($clog2(STRB_W));
  localparam logic [ID_W-1:0] ID_CONST = ID_W'(AXI_ID);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  beat_q, beat_d;
  logic        awvalid_q, awvalid_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        done_q, done_d;
  logic        done_err_q, done_err_d;
  logic        beats_left, aw_hs, w_hs, b_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      awvalid_q  <= INVALID;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      done_q     <= INVALID;
      done_err_q <= INVALID;
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  // Burst parameters only matter while BUSY/RESP, so they carry no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    len_q  <= len_d;
    size_q <= size_d;
    beat_q <= beat_d;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    beat_d     = beat_q;
    awvalid_d  = awvalid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    done_d     = INVALID;
    done_err_d = INVALID;

    req_ready  = (state_q == IDLE);
    beats_left = (state_q == BUSY) && !w_done_q;
    wvalid     = beats_left ? src_valid : INVALID;
    src_ready  = beats_left ? wready : INVALID;
    wlast      = beats_left && (beat_q == len_q);
    bready     = (state_q == RESP);
    aw_hs      = awvalid_q && awready;
    w_hs       = wvalid && wready;
    b_hs       = bvalid && bready;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_size > MAX_SIZE) begin
            done_d     = VALID;
            done_err_d = VALID;
          end else begin
            addr_d    = req_addr;
            len_d     = req_len;
            size_d    = req_size;
            beat_d    = '0;
            awvalid_d = VALID;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        if (aw_hs) begin
          awvalid_d = INVALID;
          aw_done_d = 1'b1;
        end
        // The counter parks on len after the last beat so it reads len when the burst ends.
        if (w_hs) begin
          if (wlast) w_done_d = 1'b1;
          else       beat_d   = beat_q + 4'd1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && wlast))) state_d = RESP;
      end
      RESP: begin
        if (b_hs && (bid == ID_CONST)) begin
          done_d     = VALID;
          done_err_d = (bresp == RESP_SLVERR) || (bresp == RESP_DECERR);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done     = done_q;
  assign done_err = done_err_q;
  assign awvalid  = awvalid_q;
  assign awid     = ID_CONST;
  assign wid      = ID_CONST;
  assign awaddr   = addr_q;
  assign awlen    = len_q;
  assign awsize   = size_q;
  assign awburst  = BURST_INCR;
  assign awlock   = '0;
  assign awcache  = '0;
  assign awprot   = '0;
  assign wdata    = src_data;
  assign wstrb    = src_strb;

endmodule
